gmii_rx_framer: RTL and testbench

- Receive-side frame delineator for one GMII PHY port. Runs on the PHY rx clock.
- Strips preamble and SFD, then emits a byte stream with sof/eof/err markers and per-port frame and byte statistics.
- Sits directly downstream of the PHY rx pins, alongside the passthrough stage.
- Feeds the frame-aware debug/capture logic and the seven-segment statistics muxes.

---
 rtl/gige_pkg.sv | 25 ++
 rtl/crc32_d8.sv | 31 +++
 rtl/gmii_rx_framer.sv | 180 ++++++++++++++++++
 tb/tb_gmii_rx_framer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gige_pkg.sv
// Shared constants and FSM state type for the GMII receive path.
// Used by gmii_rx_framer and its optional CRC checker.
package gige_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC32_RESIDUE = 32'hC704DD7B;

   typedef enum logic [1:0] {
      IDLE,
      PREAMBLE,
      DATA,
      DROP
   } rx_state_t;

   // The reflected CRC register holds the magic residue bit-reversed.
   function automatic logic [31:0] bit_reverse32(input logic [31:0] v);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) begin
         r[i] = v[31-i];
      end
      return r;
   endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-wide reflected CRC-32 (poly 0xEDB88320) register, no final inversion.
// init reloads 0xFFFFFFFF; en folds one byte into the running value.
module crc32_d8 (
   input  logic        clk,
   input  logic        reset,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  data,
   output logic [31:0] crc
);

   logic [31:0] crc_next;

   always_comb begin
      crc_next = crc ^ {24'd0, data};
      for (int i = 0; i < 8; i++) begin
         crc_next = crc_next[0] ? ((crc_next >> 1) ^ 32'hEDB88320) : (crc_next >> 1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         crc <= 32'hFFFFFFFF;
      end else if (init) begin
         crc <= 32'hFFFFFFFF;
      end else if (en) begin
         crc <= crc_next;
      end
   end

endmodule

// File: rtl/gmii_rx_framer.sv
// GMII receive framer: strips preamble/SFD, marks sof/eof/err, keeps statistics.
// Define GMII_RX_FRAMER_CRC_EN to add FCS checking into out_err.
module gmii_rx_framer
   import gige_pkg::*;
#(
   parameter int MIN_FRAME_LEN = 64,
   parameter int MAX_FRAME_LEN = 1518,
   parameter int COUNT_WIDTH   = 16
) (
   input  logic                   rx_clk,
   input  logic                   reset,
   input  logic                   rx_dv,
   input  logic [7:0]             rxd,
   input  logic                   rx_er,
   output logic                   out_valid,
   output logic [7:0]             out_data,
   output logic                   out_sof,
   output logic                   out_eof,
   output logic                   out_err,
   output logic [COUNT_WIDTH-1:0] rx_frame_count,
   output logic [COUNT_WIDTH-1:0] rx_bad_frame_count,
   output logic [COUNT_WIDTH-1:0] rx_drop_count,
   output logic [31:0]            rx_byte_count
);

   localparam logic [10:0] MIN_LEN = 11'(MIN_FRAME_LEN);
   localparam logic [10:0] MAX_LEN = 11'(MAX_FRAME_LEN);
   localparam logic [10:0] LEN_SAT = 11'h7FF;

   rx_state_t   state;
   logic        s1_dv;
   logic        s1_er;
   logic [7:0]  s1_rxd;
   logic        dv_prev;
   logic        hold_valid;
   logic        hold_sof;
   logic [7:0]  hold_data;
   logic        first_byte;
   logic        er_flag;
   logic [10:0] len;

   logic sfd_hit;
   logic data_byte;
   logic eof_now;
   logic err_now;
   logic crc_bad;

   assign sfd_hit   = (state == PREAMBLE) && s1_dv && (s1_rxd == SFD_BYTE);
   assign data_byte = (state == DATA) && s1_dv;
   assign eof_now   = hold_valid && !s1_dv;
   assign err_now   = er_flag || (len < MIN_LEN) || (len > MAX_LEN) || crc_bad;

`ifdef GMII_RX_FRAMER_CRC_EN
   logic [31:0] crc;

   crc32_d8 u_crc (
      .clk   (rx_clk),
      .reset (reset),
      .init  (sfd_hit),
      .en    (data_byte),
      .data  (s1_rxd),
      .crc   (crc)
   );

   assign crc_bad = (bit_reverse32(crc) != CRC32_RESIDUE);
`else
   assign crc_bad = 1'b0;
`endif

   // Reset leaves dv looking "already high" so a burst in flight at release
   // is swallowed by DROP without being counted as a discarded burst.
   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         s1_dv   <= 1'b1;
         s1_er   <= 1'b0;
         s1_rxd  <= 8'd0;
         dv_prev <= 1'b1;
      end else begin
         s1_dv   <= rx_dv;
         s1_er   <= rx_er;
         s1_rxd  <= rxd;
         dv_prev <= s1_dv;
      end
   end

   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         hold_valid    <= 1'b0;
         hold_sof      <= 1'b0;
         hold_data     <= 8'd0;
         first_byte    <= 1'b0;
         er_flag       <= 1'b0;
         len           <= 11'd0;
         rx_drop_count <= '0;
      end else begin
         hold_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (s1_dv) begin
                  if (dv_prev) begin
                     state <= DROP;
                  end else if (s1_rxd == PREAMBLE_BYTE) begin
                     state <= PREAMBLE;
                  end else begin
                     state         <= DROP;
                     rx_drop_count <= rx_drop_count + COUNT_WIDTH'(1);
                  end
               end
            end
            PREAMBLE: begin
               if (!s1_dv) begin
                  state         <= IDLE;
                  rx_drop_count <= rx_drop_count + COUNT_WIDTH'(1);
               end else if (sfd_hit) begin
                  state      <= DATA;
                  first_byte <= 1'b1;
                  er_flag    <= 1'b0;
                  len        <= 11'd0;
               end else if (s1_rxd != PREAMBLE_BYTE) begin
                  state         <= DROP;
                  rx_drop_count <= rx_drop_count + COUNT_WIDTH'(1);
               end
            end
            DATA: begin
               if (!s1_dv) begin
                  state <= IDLE;
               end else begin
                  // One-byte hold gives the lookahead needed to flag eof.
                  hold_valid <= 1'b1;
                  hold_data  <= s1_rxd;
                  hold_sof   <= first_byte;
                  first_byte <= 1'b0;
                  if (len != LEN_SAT) begin
                     len <= len + 11'd1;
                  end
                  if (s1_er) begin
                     er_flag <= 1'b1;
                  end
               end
            end
            DROP: begin
               if (!s1_dv) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge rx_clk or posedge reset) begin
      if (reset) begin
         out_valid          <= 1'b0;
         out_data           <= 8'd0;
         out_sof            <= 1'b0;
         out_eof            <= 1'b0;
         out_err            <= 1'b0;
         rx_frame_count     <= '0;
         rx_bad_frame_count <= '0;
         rx_byte_count      <= 32'd0;
      end else begin
         out_valid <= hold_valid;
         out_data  <= hold_data;
         out_sof   <= hold_valid && hold_sof;
         out_eof   <= eof_now;
         out_err   <= eof_now && err_now;
         if (hold_valid) begin
            rx_byte_count <= rx_byte_count + 32'd1;
         end
         if (eof_now) begin
            rx_frame_count <= rx_frame_count + COUNT_WIDTH'(1);
            if (err_now) begin
               rx_bad_frame_count <= rx_bad_frame_count + COUNT_WIDTH'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_gmii_rx_framer.sv
// Directed bench for gmii_rx_framer: frames, length limits, errors, drops, reset.
// Honours GMII_RX_FRAMER_CRC_EN for the corrupted-FCS expectation.
module tb_gmii_rx_framer;

   logic        rx_clk = 1'b0;
   logic        reset  = 1'b0;
   logic        rx_dv  = 1'b0;
   logic [7:0]  rxd    = 8'd0;
   logic        rx_er  = 1'b0;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_sof;
   logic        out_eof;
   logic        out_err;
   logic [15:0] rx_frame_count;
   logic [15:0] rx_bad_frame_count;
   logic [15:0] rx_drop_count;
   logic [31:0] rx_byte_count;

   gmii_rx_framer dut (
      .rx_clk             (rx_clk),
      .reset              (reset),
      .rx_dv              (rx_dv),
      .rxd                (rxd),
      .rx_er              (rx_er),
      .out_valid          (out_valid),
      .out_data           (out_data),
      .out_sof            (out_sof),
      .out_eof            (out_eof),
      .out_err            (out_err),
      .rx_frame_count     (rx_frame_count),
      .rx_bad_frame_count (rx_bad_frame_count),
      .rx_drop_count      (rx_drop_count),
      .rx_byte_count      (rx_byte_count)
   );

   always #5 rx_clk = ~rx_clk;

   int cyc = 0;
   always @(posedge rx_clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0] d;
      logic       sof;
      logic       eof;
      logic       err;
      int         cyc;
   } ob_t;

   ob_t        mon_q[$];
   logic [7:0] exp_q[$];
   logic       errs[$];
   logic [7:0] frm[0:1599];
   int         data_cyc;
   int         checks = 0;
   int         failures = 0;

   int   st_n, st_nsof, st_neof, st_nerr, st_data_bad, st_first_cyc;
   logic st_first_sof, st_last_sof, st_last_eof, st_last_err;

   always @(negedge rx_clk) begin
      if (out_valid === 1'b1)
         mon_q.push_back('{out_data, out_sof, out_eof, out_err, cyc});
   end

   task automatic drive(input logic dv, input logic [7:0] d, input logic er);
      @(negedge rx_clk);
      rx_dv = dv;
      rxd   = d;
      rx_er = er;
   endtask

   task automatic idle(input int k);
      repeat (k) drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic clear_obs();
      mon_q.delete();
      exp_q.delete();
      errs.delete();
   endtask

   task automatic apply_reset();
      @(negedge rx_clk);
      reset = 1'b1;
      rx_dv = 1'b0;
      rxd   = 8'h00;
      rx_er = 1'b0;
      repeat (3) @(negedge rx_clk);
      reset = 1'b0;
      idle(4);
      clear_obs();
   endtask

   // Standard Ethernet FCS: reflected CRC-32 over the payload, complemented, LSB first.
   task automatic build_frame(input int n, input int seed, input bit corrupt);
      logic [31:0] c;
      for (int i = 0; i < n; i++) frm[i] = 8'(i * 37 + seed);
      if (n >= 4) begin
         c = 32'hFFFFFFFF;
         for (int i = 0; i < n - 4; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
         end
         c = ~c;
         frm[n-4] = c[7:0];
         frm[n-3] = c[15:8];
         frm[n-2] = c[23:16];
         frm[n-1] = c[31:24];
      end
      if (corrupt) frm[n-1] = frm[n-1] ^ 8'h08;
   endtask

   task automatic send_frame(input int n, input int seed, input int er_idx, input bit corrupt);
      build_frame(n, seed, corrupt);
      repeat (7) drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < n; i++) begin
         drive(1'b1, frm[i], (i == er_idx));
         if (i == 0) data_cyc = cyc;
         exp_q.push_back(frm[i]);
      end
      drive(1'b0, 8'h00, 1'b0);
   endtask

   task automatic collect();
      int fb;
      idle(6);
      st_n = mon_q.size();
      st_nsof = 0; st_neof = 0; st_nerr = 0; st_data_bad = 0; fb = 0;
      st_first_sof = 1'b0; st_last_sof = 1'b0; st_last_eof = 1'b0; st_last_err = 1'b0;
      st_first_cyc = -1;
      for (int i = 0; i < st_n; i++) begin
         fb++;
         if (mon_q[i].sof) st_nsof++;
         if (i < exp_q.size() && mon_q[i].d !== exp_q[i]) st_data_bad++;
         if (mon_q[i].eof) begin
            st_neof++;
            errs.push_back(mon_q[i].err);
            if (mon_q[i].err) st_nerr++;
            $display("frame: bytes=%0d err=%0d at cycle %0d", fb, mon_q[i].err, mon_q[i].cyc);
            fb = 0;
         end
      end
      if (st_n > 0) begin
         st_first_sof = mon_q[0].sof;
         st_first_cyc = mon_q[0].cyc;
         st_last_sof  = mon_q[st_n-1].sof;
         st_last_eof  = mon_q[st_n-1].eof;
         st_last_err  = mon_q[st_n-1].err;
      end
   endtask

   task automatic test_reset();
      #2 reset = 1'b1;
      rx_dv = 1'b1;
      rxd   = 8'h55;
      repeat (3) @(negedge rx_clk);
      checks++; if ({out_valid, out_sof, out_eof, out_err} !== 4'b0000) begin failures++; $display("FAIL reset_flags: got %b want 0000", {out_valid, out_sof, out_eof, out_err}); end
      checks++; if (out_data !== 8'h00) begin failures++; $display("FAIL reset_data: got %h want 00", out_data); end
      checks++; if (rx_frame_count !== 16'd0) begin failures++; $display("FAIL reset_frames: got %0d want 0", rx_frame_count); end
      checks++; if (rx_bad_frame_count !== 16'd0) begin failures++; $display("FAIL reset_bad: got %0d want 0", rx_bad_frame_count); end
      checks++; if (rx_drop_count !== 16'd0) begin failures++; $display("FAIL reset_drops: got %0d want 0", rx_drop_count); end
      checks++; if (rx_byte_count !== 32'd0) begin failures++; $display("FAIL reset_bytes: got %0d want 0", rx_byte_count); end
      checks++; if (mon_q.size() != 0) begin failures++; $display("FAIL reset_no_output: got %0d bytes want 0", mon_q.size()); end
      reset = 1'b0;
      rx_dv = 1'b0;
      idle(4);
   endtask

   task automatic test_good_frame();
      apply_reset();
      send_frame(64, 1, -1, 1'b0);
      collect();
      checks++; if (st_n != 64) begin failures++; $display("FAIL good_count: got %0d want 64", st_n); end
      checks++; if (st_first_sof !== 1'b1 || st_nsof != 1) begin failures++; $display("FAIL good_sof: got first=%b n=%0d want 1/1", st_first_sof, st_nsof); end
      checks++; if (st_last_eof !== 1'b1 || st_neof != 1) begin failures++; $display("FAIL good_eof: got last=%b n=%0d want 1/1", st_last_eof, st_neof); end
      checks++; if (st_last_err !== 1'b0) begin failures++; $display("FAIL good_err: got %b want 0", st_last_err); end
      checks++; if (st_data_bad != 0) begin failures++; $display("FAIL good_data: got %0d bad bytes want 0", st_data_bad); end
      checks++; if (st_first_cyc != data_cyc + 3) begin failures++; $display("FAIL good_latency: got cycle %0d want %0d", st_first_cyc, data_cyc + 3); end
      checks++; if (rx_frame_count !== 16'd1) begin failures++; $display("FAIL good_frames: got %0d want 1", rx_frame_count); end
      checks++; if (rx_bad_frame_count !== 16'd0) begin failures++; $display("FAIL good_bad: got %0d want 0", rx_bad_frame_count); end
      checks++; if (rx_byte_count !== 32'd64) begin failures++; $display("FAIL good_bytes: got %0d want 64", rx_byte_count); end
   endtask

   task automatic test_rx_er();
      apply_reset();
      send_frame(64, 2, 9, 1'b0);
      collect();
      checks++; if (st_n != 64) begin failures++; $display("FAIL er_count: got %0d want 64", st_n); end
      checks++; if (st_last_eof !== 1'b1 || st_last_err !== 1'b1) begin failures++; $display("FAIL er_err: got eof=%b err=%b want 1/1", st_last_eof, st_last_err); end
      checks++; if (rx_bad_frame_count !== 16'd1) begin failures++; $display("FAIL er_bad: got %0d want 1", rx_bad_frame_count); end
      checks++; if (rx_frame_count !== 16'd1) begin failures++; $display("FAIL er_frames: got %0d want 1", rx_frame_count); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      send_frame(40, 3, -1, 1'b0);
      send_frame(1600, 4, -1, 1'b0);
      collect();
      checks++; if (st_n != 1640) begin failures++; $display("FAIL b2b_count: got %0d want 1640", st_n); end
      checks++; if (st_nsof != 2 || st_neof != 2 || st_nerr != 2) begin failures++; $display("FAIL b2b_marks: got sof=%0d eof=%0d err=%0d want 2/2/2", st_nsof, st_neof, st_nerr); end
      checks++; if (st_n < 41 || mon_q[39].eof !== 1'b1 || mon_q[40].sof !== 1'b1) begin failures++; $display("FAIL b2b_order: got eof40/sof41 missing want present"); end
      checks++; if (st_data_bad != 0) begin failures++; $display("FAIL b2b_data: got %0d bad bytes want 0", st_data_bad); end
      checks++; if (rx_bad_frame_count !== 16'd2) begin failures++; $display("FAIL b2b_bad: got %0d want 2", rx_bad_frame_count); end
      checks++; if (rx_byte_count !== 32'd1640) begin failures++; $display("FAIL b2b_bytes: got %0d want 1640", rx_byte_count); end
      checks++; if (rx_frame_count !== 16'd2) begin failures++; $display("FAIL b2b_frames: got %0d want 2", rx_frame_count); end
   endtask

   task automatic test_len_bounds();
      logic exp_err[4];
      exp_err = '{1'b1, 1'b0, 1'b1, 1'b1};
      apply_reset();
      send_frame(63, 5, -1, 1'b0);
      send_frame(1518, 6, -1, 1'b0);
      send_frame(1519, 7, -1, 1'b0);
      send_frame(1, 8, -1, 1'b0);
      collect();
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (k >= errs.size() || errs[k] !== exp_err[k]) begin
            failures++;
            $display("FAIL len_err%0d: got %b want %b", k, (k < errs.size()) ? errs[k] : 1'bx, exp_err[k]);
         end
      end
      checks++; if (st_last_sof !== 1'b1 || st_last_eof !== 1'b1) begin failures++; $display("FAIL len_one_byte: got sof=%b eof=%b want 1/1", st_last_sof, st_last_eof); end
      checks++; if (rx_byte_count !== 32'd3101) begin failures++; $display("FAIL len_bytes: got %0d want 3101", rx_byte_count); end
      checks++; if (rx_frame_count !== 16'd4 || rx_bad_frame_count !== 16'd3) begin failures++; $display("FAIL len_counts: got %0d/%0d want 4/3", rx_frame_count, rx_bad_frame_count); end
   endtask

   task automatic test_bad_preamble();
      apply_reset();
      drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h5D, 1'b0);
      drive(1'b1, 8'h12, 1'b0); drive(1'b1, 8'hD5, 1'b0); drive(1'b1, 8'h34, 1'b0);
      idle(3);
      repeat (3) drive(1'b0, 8'h0F, 1'b1);
      drive(1'b1, 8'hAA, 1'b0); drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'hD5, 1'b0); drive(1'b1, 8'h77, 1'b0);
      idle(3);
      drive(1'b1, 8'h55, 1'b0); drive(1'b1, 8'h55, 1'b0);
      idle(3);
      checks++; if (rx_drop_count !== 16'd3) begin failures++; $display("FAIL drop_count: got %0d want 3", rx_drop_count); end
      checks++; if (mon_q.size() != 0) begin failures++; $display("FAIL drop_no_output: got %0d bytes want 0", mon_q.size()); end
      send_frame(64, 9, -1, 1'b0);
      collect();
      checks++; if (st_n != 64 || st_data_bad != 0) begin failures++; $display("FAIL drop_next_frame: got %0d bytes %0d bad want 64/0", st_n, st_data_bad); end
      checks++; if (rx_frame_count !== 16'd1 || st_last_err !== 1'b0) begin failures++; $display("FAIL drop_next_counts: got frames=%0d err=%b want 1/0", rx_frame_count, st_last_err); end
   endtask

   task automatic test_reset_mid_frame();
      apply_reset();
      repeat (7) drive(1'b1, 8'h55, 1'b0);
      drive(1'b1, 8'hD5, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b1, 8'(i + 100), 1'b0);
      @(negedge rx_clk);
      reset = 1'b1;
      @(negedge rx_clk);
      clear_obs();
      @(negedge rx_clk);
      reset = 1'b0;
      for (int i = 0; i < 10; i++) drive(1'b1, 8'(i + 120), 1'b0);
      idle(6);
      checks++; if (mon_q.size() != 0) begin failures++; $display("FAIL mid_no_output: got %0d bytes want 0", mon_q.size()); end
      checks++; if (rx_frame_count !== 16'd0 || rx_byte_count !== 32'd0) begin failures++; $display("FAIL mid_counts: got frames=%0d bytes=%0d want 0/0", rx_frame_count, rx_byte_count); end
      checks++; if (rx_drop_count !== 16'd0 || rx_bad_frame_count !== 16'd0) begin failures++; $display("FAIL mid_drop_bad: got %0d/%0d want 0/0", rx_drop_count, rx_bad_frame_count); end
      send_frame(64, 10, -1, 1'b0);
      collect();
      checks++; if (rx_frame_count !== 16'd1 || st_n != 64) begin failures++; $display("FAIL mid_next_frame: got frames=%0d bytes=%0d want 1/64", rx_frame_count, st_n); end
      checks++; if (st_last_err !== 1'b0) begin failures++; $display("FAIL mid_next_err: got %b want 0", st_last_err); end
   endtask

   task automatic test_fcs_corrupt();
      logic want;
`ifdef GMII_RX_FRAMER_CRC_EN
      want = 1'b1;
`else
      want = 1'b0;
`endif
      apply_reset();
      send_frame(64, 11, -1, 1'b1);
      collect();
      checks++; if (st_last_eof !== 1'b1 || st_last_err !== want) begin failures++; $display("FAIL fcs_err: got eof=%b err=%b want 1/%b", st_last_eof, st_last_err, want); end
      checks++; if (rx_bad_frame_count !== {15'd0, want}) begin failures++; $display("FAIL fcs_bad: got %0d want %0d", rx_bad_frame_count, want); end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_rx_er();
      test_back_to_back();
      test_len_bounds();
      test_bad_preamble();
      test_reset_mid_frame();
      test_fcs_corrupt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
